// File: rtl/bounce_pkg.sv
// bounce_pkg: shared definitions for the bounce generator slice.
//   state_t           - FSM state encoding (IDLE / BOUNCE / SETTLE)
//   LFSR_W            - width of the pseudo-random source
//   LFSR_TAPS         - Galois tap mask for x^16+x^14+x^13+x^11+1
//   LFSR_SEED_DEFAULT - default nonzero reset value of the LFSR
//   lfsr_step()       - one right-shifting Galois step
package bounce_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    SETTLE = 2'd2
  } state_t;

  localparam int unsigned LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS         = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 16'hACE1;

  // Right shift; when the bit shifted out is 1, fold the taps back in.
  // A nonzero state never maps to zero.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return {1'b0, v[LFSR_W-1:1]} ^ (v[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/bounce_generator_lfsr.sv
// lfsr16: free-running 16-bit Galois LFSR, advances every clk cycle.
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset, loads seed
//   seed  - reset value (must be nonzero)
//   q     - current LFSR state
module lfsr16
  import bounce_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= seed;
    end else begin
      q <= lfsr_step(q);
    end
  end

endmodule

// File: rtl/bounce_generator.sv
// bounce_generator: turns an ideal switch level into a bouncing copy, as
// stimulus for a debouncer. Each transition produces an odd number of noisy
// edges at pseudo-random spacing, followed by a stable settle period.
//   clk    - rising-edge clock
//   reset  - asynchronous active-high reset
//   enable - 1: bounce emulation, 0: registered pass-through
//   clean  - ideal switch level, synchronous to clk
//   noisy  - registered bouncing copy of clean
//   busy   - high while a transition is in progress
//   done   - one-cycle pulse when the settle period completes
module bounce_generator
  import bounce_pkg::*;
#(
  parameter int unsigned       PAIRS_MIN     = 2,
  parameter int unsigned       PAIRS_W       = 2,
  parameter int unsigned       INTERVAL_MIN  = 16,
  parameter int unsigned       INTERVAL_W    = 4,
  parameter int unsigned       SETTLE_CYCLES = 64,
  parameter logic [LFSR_W-1:0] LFSR_SEED     = LFSR_SEED_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clean,
  output logic noisy,
  output logic busy,
  output logic done
);

  localparam int unsigned REM_MAX = 2 * (PAIRS_MIN + (1 << PAIRS_W) - 1);
  localparam int unsigned REM_W   = $clog2(REM_MAX + 1);
  localparam int unsigned INT_MAX = INTERVAL_MIN + (1 << INTERVAL_W) - 1;
  localparam int unsigned INT_W   = $clog2(INT_MAX + 1);
  localparam int unsigned SET_W   = $clog2(SETTLE_CYCLES + 1);

  state_t             state_q, state_d;
  logic               noisy_q, noisy_d;
  logic               target_q, target_d;
  logic               done_q, done_d;
  logic [REM_W-1:0]   rem_q, rem_d, rem_load;
  logic [INT_W-1:0]   int_q, int_d, int_load;
  logic [SET_W-1:0]   set_q, set_d;
  logic [LFSR_W-1:0]  lfsr;
  logic               lfsr_unused;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (LFSR_SEED),
    .q     (lfsr)
  );

  // Only the low PAIRS_W+INTERVAL_W bits feed the counters.
  assign lfsr_unused = ^lfsr;

  // Remaining toggles is always even so the last toggle lands on target.
  assign rem_load = REM_W'(2 * (PAIRS_MIN + 32'(lfsr[PAIRS_W-1:0])));
  assign int_load = INT_W'(INTERVAL_MIN + 32'(lfsr[PAIRS_W+INTERVAL_W-1:PAIRS_W]));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      noisy_q  <= 1'b0;
      target_q <= 1'b0;
      done_q   <= 1'b0;
      rem_q    <= '0;
      int_q    <= '0;
      set_q    <= '0;
    end else begin
      state_q  <= state_d;
      noisy_q  <= noisy_d;
      target_q <= target_d;
      done_q   <= done_d;
      rem_q    <= rem_d;
      int_q    <= int_d;
      set_q    <= set_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    noisy_d  = noisy_q;
    target_d = target_q;
    done_d   = 1'b0;
    rem_d    = rem_q;
    int_d    = int_q;
    set_d    = set_q;

    if (!enable) begin
      state_d  = IDLE;
      noisy_d  = clean;
      target_d = clean;
      rem_d    = '0;
      int_d    = '0;
      set_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (clean != noisy_q) begin
            noisy_d  = clean;
            target_d = clean;
            rem_d    = rem_load;
            int_d    = int_load;
            state_d  = BOUNCE;
          end
        end
        BOUNCE: begin
          if (clean != target_q) begin
            // Retarget: restart the sequence toward the new level.
            noisy_d  = clean;
            target_d = clean;
            rem_d    = rem_load;
            int_d    = int_load;
          end else if (int_q <= INT_W'(1)) begin
            // Toggle on the cycle the interval would reach zero, so the
            // spacing equals the loaded interval.
            noisy_d = ~noisy_q;
            rem_d   = rem_q - REM_W'(1);
            int_d   = int_load;
            if (rem_q <= REM_W'(1)) begin
              int_d   = '0;
              set_d   = SET_W'(SETTLE_CYCLES);
              state_d = SETTLE;
            end
          end else begin
            int_d = int_q - INT_W'(1);
          end
        end
        SETTLE: begin
          if (set_q <= SET_W'(1)) begin
            set_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            set_d = set_q - SET_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign noisy = noisy_q;
  // Gated by enable so pass-through never shows busy/done, even on the
  // cycle enable falls.
  assign busy  = enable && (state_q != IDLE);
  assign done  = enable && done_q;

endmodule

// File: tb/tb_bounce_generator.sv
// tb_bounce_generator: directed bench with an event scoreboard. Driving a
// clean change pushes the predicted noisy edges and done pulse (computed from
// an independent LFSR model); a negedge monitor pops and compares them.
module tb_bounce_generator;

  localparam int unsigned P_MIN  = 2;
  localparam int unsigned P_W    = 2;
  localparam int unsigned I_MIN  = 16;
  localparam int unsigned I_W    = 4;
  localparam int unsigned SETTLE = 64;
  localparam logic [15:0] SEED   = 16'hACE1;

  typedef struct packed {
    int   cyc;
    logic kind;  // 0: noisy edge, 1: done pulse
    logic val;   // noisy level at the event
  } ev_t;

  logic clk, reset, enable, clean;
  logic noisy, busy, done;

  ev_t  exp_q[$];
  int   n_vec, n_miss;
  int   n_edges, n_done;
  int   ecount;
  logic [15:0] m_lfsr;

  bounce_generator #(
    .PAIRS_MIN     (P_MIN),
    .PAIRS_W       (P_W),
    .INTERVAL_MIN  (I_MIN),
    .INTERVAL_W    (I_W),
    .SETTLE_CYCLES (SETTLE),
    .LFSR_SEED     (SEED)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .clean  (clean),
    .noisy  (noisy),
    .busy   (busy),
    .done   (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Polynomial x^16+x^14+x^13+x^11+1, Galois form, shifting right.
  function automatic logic [15:0] adv(input logic [15:0] v, input int n);
    logic [15:0] x;
    logic fb;
    x = v;
    for (int i = 0; i < n; i++) begin
      fb = x[0];
      x  = x >> 1;
      if (fb) begin
        x[15] = ~x[15];
        x[13] = ~x[13];
        x[12] = ~x[12];
        x[10] = ~x[10];
      end
    end
    return x;
  endfunction

  // Reference LFSR and edge counter: m_lfsr is the value the DUT's LFSR
  // holds before edge ecount+1.
  initial begin
    m_lfsr = SEED;
    ecount = 0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_lfsr = SEED;
        ecount = 0;
      end else begin
        m_lfsr = adv(m_lfsr, 1);
        ecount = ecount + 1;
      end
    end
  end

  // Monitor: every noisy edge or done pulse is one scoreboard event.
  initial begin
    ev_t obs, expv;
    logic prev_noisy;
    prev_noisy = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_noisy = noisy;
      end else if (noisy !== prev_noisy || done === 1'b1) begin
        obs.cyc  = ecount;
        obs.kind = done;
        obs.val  = noisy;
        if (noisy !== prev_noisy) n_edges = n_edges + 1;
        if (done === 1'b1) n_done = n_done + 1;
        n_vec = n_vec + 1;
        if (exp_q.size() == 0) begin
          n_miss = n_miss + 1;
          $error("FAIL sb_unexpected: observed cyc=%0d kind=%0d val=%0d, expected no event",
                 obs.cyc, obs.kind, obs.val);
        end else begin
          expv = exp_q.pop_front();
          assert (obs === expv) else begin
            n_miss = n_miss + 1;
            $error("FAIL sb_event: observed cyc=%0d kind=%0d val=%0d, expected cyc=%0d kind=%0d val=%0d",
                   obs.cyc, obs.kind, obs.val, expv.cyc, expv.kind, expv.val);
          end
        end
        prev_noisy = noisy;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec = n_vec + 1;
    assert (obs === expv) else begin
      n_miss = n_miss + 1;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // Predict a whole transition whose first edge lands on edge e with level v.
  task automatic push_schedule(input logic v, input int e);
    logic [15:0] l;
    int   t, n, rem;
    logic cur;
    l   = adv(m_lfsr, e - (ecount + 1));
    exp_q.push_back('{cyc: e, kind: 1'b0, val: v});
    rem = 2 * (P_MIN + int'(l[P_W-1:0]));
    n   = I_MIN + int'(l[P_W+I_W-1:P_W]);
    t   = e;
    cur = v;
    while (rem > 0) begin
      l   = adv(l, n);
      t   = t + n;
      cur = ~cur;
      exp_q.push_back('{cyc: t, kind: 1'b0, val: cur});
      rem = rem - 1;
      n   = I_MIN + int'(l[P_W+I_W-1:P_W]);
    end
    exp_q.push_back('{cyc: t + SETTLE, kind: 1'b1, val: cur});
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && busy === 1'b0) break;
      tick();
    end
    check1({tag, "_pending_events"}, exp_q.size(), 0);
    check1({tag, "_busy_after"}, {31'b0, busy}, 0);
    exp_q.delete();
  endtask

  task automatic wait_edges(input string tag, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (n_edges >= n) break;
      tick();
    end
    check1({tag, "_edges_reached"}, (n_edges >= n) ? 1 : 0, 1);
  endtask

  initial begin
    int d0, dcyc;
    n_vec = 0; n_miss = 0; n_edges = 0; n_done = 0;
    reset = 1'b1; enable = 1'b1; clean = 1'b0;

    // Reset idle
    repeat (3) tick();
    check1("rst_noisy", {31'b0, noisy}, 0);
    check1("rst_busy",  {31'b0, busy},  0);
    check1("rst_done",  {31'b0, done},  0);
    reset = 1'b0;
    repeat (100) tick();
    check1("idle_noisy", {31'b0, noisy}, 0);
    check1("idle_busy",  {31'b0, busy},  0);
    check1("idle_done_count", n_done, 0);

    // Rising transition
    n_edges = 0; d0 = n_done;
    clean = 1'b1;
    push_schedule(1'b1, ecount + 1);
    wait_idle("rise", 700);
    check1("rise_final_noisy", {31'b0, noisy}, 1);
    check1("rise_edge_count_odd_5_11",
           (n_edges % 2 == 1 && n_edges >= 5 && n_edges <= 11) ? 1 : 0, 1);
    check1("rise_done_count", n_done - d0, 1);

    // Falling transition
    n_edges = 0; d0 = n_done;
    clean = 1'b0;
    push_schedule(1'b0, ecount + 1);
    wait_idle("fall", 700);
    check1("fall_final_noisy", {31'b0, noisy}, 0);
    check1("fall_edge_count_odd_5_11",
           (n_edges % 2 == 1 && n_edges >= 5 && n_edges <= 11) ? 1 : 0, 1);

    // Retarget after the third noisy edge
    n_edges = 0; d0 = n_done;
    clean = 1'b1;
    push_schedule(1'b1, ecount + 1);
    wait_edges("retgt", 3, 200);
    check1("retgt_busy_mid", {31'b0, busy}, 1);
    clean = 1'b0;
    exp_q.delete();
    push_schedule(1'b0, ecount + 1);
    wait_idle("retgt", 900);
    check1("retgt_final_noisy", {31'b0, noisy}, 0);
    check1("retgt_done_count", n_done - d0, 1);

    // Clean changes deferred while settling
    n_edges = 0; d0 = n_done;
    clean = 1'b1;
    push_schedule(1'b1, ecount + 1);
    for (int i = 0; i < 600; i++) begin
      if (exp_q.size() <= 1) break;
      tick();
    end
    repeat (3) tick();
    check1("defer_busy_in_settle", {31'b0, busy}, 1);
    check1("defer_noisy_in_settle", {31'b0, noisy}, 1);
    dcyc = exp_q[0].cyc;
    clean = 1'b0;
    push_schedule(1'b0, dcyc + 1);
    tick();
    clean = 1'b1;
    tick();
    clean = 1'b0;
    wait_idle("defer", 1200);
    check1("defer_final_noisy", {31'b0, noisy}, 0);
    check1("defer_done_count", n_done - d0, 2);

    // Pass-through
    enable = 1'b0;
    tick();
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) begin
        clean = ~clean;
        exp_q.push_back('{cyc: ecount + 1, kind: 1'b0, val: clean});
      end
      tick();
      check1("pass_noisy_eq_clean_d1", {31'b0, noisy}, {31'b0, clean});
      check1("pass_busy", {31'b0, busy}, 0);
    end
    check1("pass_pending_events", exp_q.size(), 0);
    enable = 1'b1;
    tick();

    // Start from reset with clean=1, then reset mid-BOUNCE and repeat
    reset = 1'b1;
    clean = 1'b1;
    repeat (3) tick();
    n_edges = 0; d0 = n_done;
    reset = 1'b0;
    push_schedule(1'b1, 1);
    wait_edges("rstmid", 1, 10);
    repeat (4) tick();
    check1("rstmid_busy_before", {31'b0, busy}, 1);
    reset = 1'b1;
    #1;
    check1("rstmid_async_noisy", {31'b0, noisy}, 0);
    check1("rstmid_async_busy",  {31'b0, busy},  0);
    check1("rstmid_async_done",  {31'b0, done},  0);
    exp_q.delete();
    repeat (3) tick();
    reset = 1'b0;
    push_schedule(1'b1, 1);
    wait_idle("rstrep", 700);
    check1("rstrep_final_noisy", {31'b0, noisy}, 1);
    check1("rstrep_done_count", n_done - d0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
